mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_decode.sv | 80 ++++++++
 rtl/mc_cu.sv | 156 +++++++++++++++
 tb/tb_mc_cu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg
// Shared constants for the multicycle control unit: FSM state codes,
// ALU operation codes, PC source selects, opcode/func encodings and the
// decoded-instruction record passed from mc_decode to mc_cu.
// Ports: none (package).
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef struct packed {
    logic       valid;
    logic       isJump;
    logic       isJal;
    logic       isJr;
    logic       isBeq;
    logic       isBne;
    logic       isLoad;
    logic       isStore;
    logic       regrt;
    logic       m2reg;
    logic       shift;
    logic       aluimm;
    logic       sext;
    logic [3:0] aluc;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode
// Purely combinational instruction decoder. Classifies the instruction
// for the FSM and produces the datapath selects, which are state-independent.
// Ports:
//   i_op   [5:0] in  : opcode field IR[31:26]
//   i_func [5:0] in  : function field IR[5:0]
//   o_dec  dec_t out : decoded record (valid=0 means undecodable)
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  // Start from an all-zero (invalid) record so only recognised encodings
  // raise valid; anything unmatched falls through as illegal.
  always_comb begin
    o_dec = '0;
    unique case (i_op)
      OP_RTYPE: begin
        o_dec.valid = 1'b1;
        case (i_func)
          FN_ADD:  o_dec.aluc = ALU_ADD;
          FN_SUB:  o_dec.aluc = ALU_SUB;
          FN_AND:  o_dec.aluc = ALU_AND;
          FN_OR:   o_dec.aluc = ALU_OR;
          FN_XOR:  o_dec.aluc = ALU_XOR;
          FN_SLL:  begin o_dec.aluc = ALU_SLL; o_dec.shift = 1'b1; end
          FN_SRL:  begin o_dec.aluc = ALU_SRL; o_dec.shift = 1'b1; end
          FN_SRA:  begin o_dec.aluc = ALU_SRA; o_dec.shift = 1'b1; end
          FN_JR:   o_dec.isJr = 1'b1;
          default: o_dec.valid = 1'b0;
        endcase
      end
      OP_ADDI: begin
        o_dec.valid = 1'b1; o_dec.regrt = 1'b1; o_dec.aluimm = 1'b1;
        o_dec.sext = 1'b1; o_dec.aluc = ALU_ADD;
      end
      OP_ANDI: begin
        o_dec.valid = 1'b1; o_dec.regrt = 1'b1; o_dec.aluimm = 1'b1;
        o_dec.aluc = ALU_AND;
      end
      OP_ORI: begin
        o_dec.valid = 1'b1; o_dec.regrt = 1'b1; o_dec.aluimm = 1'b1;
        o_dec.aluc = ALU_OR;
      end
      OP_XORI: begin
        o_dec.valid = 1'b1; o_dec.regrt = 1'b1; o_dec.aluimm = 1'b1;
        o_dec.aluc = ALU_XOR;
      end
      OP_LUI: begin
        o_dec.valid = 1'b1; o_dec.regrt = 1'b1; o_dec.aluimm = 1'b1;
        o_dec.aluc = ALU_LUI;
      end
      OP_LW: begin
        o_dec.valid = 1'b1; o_dec.isLoad = 1'b1; o_dec.regrt = 1'b1;
        o_dec.m2reg = 1'b1; o_dec.aluimm = 1'b1; o_dec.sext = 1'b1;
        o_dec.aluc = ALU_ADD;
      end
      OP_SW: begin
        o_dec.valid = 1'b1; o_dec.isStore = 1'b1; o_dec.aluimm = 1'b1;
        o_dec.sext = 1'b1; o_dec.aluc = ALU_ADD;
      end
      // Branches compare with xor; the zero flag then means "equal".
      OP_BEQ: begin
        o_dec.valid = 1'b1; o_dec.isBeq = 1'b1; o_dec.sext = 1'b1;
        o_dec.aluc = ALU_XOR;
      end
      OP_BNE: begin
        o_dec.valid = 1'b1; o_dec.isBne = 1'b1; o_dec.sext = 1'b1;
        o_dec.aluc = ALU_XOR;
      end
      OP_J:    begin o_dec.valid = 1'b1; o_dec.isJump = 1'b1; end
      OP_JAL:  begin o_dec.valid = 1'b1; o_dec.isJal = 1'b1; end
      default: o_dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// mc_cu
// Multicycle control unit: IF/ID/EXE/MEM/WB FSM plus memory wait counter.
// Parameters:
//   MEM_HS  : 1 = memory access completes on mem_ready, 0 = fixed latency
//   MEM_LAT : cycles per access when MEM_HS=0 (1..15)
// Ports:
//   clock, reset (sync, active-high)
//   op, func, z, mem_ready                    : inputs
//   mem_req, iord, wir, wpc, wmem, wreg       : enables / address select
//   pcsource[1:0]                             : next-PC select
//   regrt, m2reg, jal, shift, aluimm, sext    : datapath selects
//   aluc[3:0], illegal, state[2:0]            : ALU op, illegal pulse, debug
module mc_cu
  import mc_pkg::*;
#(
  parameter int MEM_HS  = 1,
  parameter int MEM_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       wir,
  output logic       wpc,
  output logic [1:0] pcsource,
  output logic       wmem,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       aluimm,
  output logic       sext,
  output logic [3:0] aluc,
  output logic       illegal,
  output logic [2:0] state
);

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  dec_t       w_dec;
  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait;
  logic       w_inAccess;
  logic       w_done;
  logic       w_memReq;
  logic       w_wir;
  logic       w_wpc;
  logic       w_wmem;
  logic       w_wreg;
  logic       w_illegal;

  mc_decode u_decode (
    .i_op   (op),
    .i_func (func),
    .o_dec  (w_dec)
  );

  assign w_inAccess = (r_state == S_IF) || (r_state == S_MEM);
  // The counter restarts whenever an access finishes or we are outside
  // IF/MEM, so every new access starts counting from zero.
  assign w_done = (MEM_HS != 0) ? mem_ready : (r_wait == LAST_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IF;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (!w_inAccess || w_done) r_wait <= '0;
      else                       r_wait <= r_wait + 4'd1;
    end
  end

  always_comb begin
    w_next    = S_IF;
    w_memReq  = 1'b0;
    iord      = 1'b0;
    w_wir     = 1'b0;
    w_wpc     = 1'b0;
    w_wmem    = 1'b0;
    w_wreg    = 1'b0;
    w_illegal = 1'b0;
    pcsource  = PC_PLUS4;
    case (r_state)
      S_IF: begin
        w_memReq = 1'b1;
        if (w_done) begin
          w_wir  = 1'b1;
          w_wpc  = 1'b1;
          w_next = S_ID;
        end else begin
          w_next = S_IF;
        end
      end
      S_ID: begin
        if (!w_dec.valid) begin
          w_illegal = 1'b1;
        end else if (w_dec.isJump || w_dec.isJal) begin
          w_wpc    = 1'b1;
          pcsource = PC_JUMP;
          w_wreg   = w_dec.isJal;
        end else if (w_dec.isJr) begin
          w_wpc    = 1'b1;
          pcsource = PC_REG;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        if (w_dec.isBeq || w_dec.isBne) begin
          w_wpc    = (w_dec.isBeq & z) | (w_dec.isBne & ~z);
          pcsource = PC_BRANCH;
        end else if (w_dec.isLoad || w_dec.isStore) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_memReq = 1'b1;
        iord     = 1'b1;
        w_wmem   = w_dec.isStore;
        if (w_done) w_next = w_dec.isLoad ? S_WB : S_IF;
        else        w_next = S_MEM;
      end
      S_WB: begin
        w_wreg = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

  // Reset forces every enable low immediately, including a store in MEM.
  assign mem_req = w_memReq  & ~reset;
  assign wir     = w_wir     & ~reset;
  assign wpc     = w_wpc     & ~reset;
  assign wmem    = w_wmem    & ~reset;
  assign wreg    = w_wreg    & ~reset;
  assign illegal = w_illegal & ~reset;

  assign regrt  = w_dec.regrt;
  assign m2reg  = w_dec.m2reg;
  assign jal    = w_dec.isJal;
  assign shift  = w_dec.shift;
  assign aluimm = w_dec.aluimm;
  assign sext   = w_dec.sext;
  assign aluc   = w_dec.aluc;
  assign state  = r_state;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu
// Directed bench for mc_cu. Three instances share the inputs:
//   0: MEM_HS=0, MEM_LAT=1   1: MEM_HS=1   2: MEM_HS=0, MEM_LAT=3
// Inputs change 1 time unit after the falling edge, outputs are checked
// one further unit later, well away from the rising edge.
module tb_mc_cu;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       memReady;

  logic       memReq [3];
  logic       iord   [3];
  logic       wir    [3];
  logic       wpc    [3];
  logic [1:0] pcsrc  [3];
  logic       wmem   [3];
  logic       wreg   [3];
  logic       regrt  [3];
  logic       m2reg  [3];
  logic       jal    [3];
  logic       shift  [3];
  logic       aluimm [3];
  logic       sext   [3];
  logic [3:0] aluc   [3];
  logic       illeg  [3];
  logic [2:0] st     [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mc_cu #(.MEM_HS(0), .MEM_LAT(1)) dutA (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(memReady),
    .mem_req(memReq[0]), .iord(iord[0]), .wir(wir[0]), .wpc(wpc[0]), .pcsource(pcsrc[0]),
    .wmem(wmem[0]), .wreg(wreg[0]), .regrt(regrt[0]), .m2reg(m2reg[0]), .jal(jal[0]),
    .shift(shift[0]), .aluimm(aluimm[0]), .sext(sext[0]), .aluc(aluc[0]),
    .illegal(illeg[0]), .state(st[0]));

  mc_cu #(.MEM_HS(1), .MEM_LAT(2)) dutB (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(memReady),
    .mem_req(memReq[1]), .iord(iord[1]), .wir(wir[1]), .wpc(wpc[1]), .pcsource(pcsrc[1]),
    .wmem(wmem[1]), .wreg(wreg[1]), .regrt(regrt[1]), .m2reg(m2reg[1]), .jal(jal[1]),
    .shift(shift[1]), .aluimm(aluimm[1]), .sext(sext[1]), .aluc(aluc[1]),
    .illegal(illeg[1]), .state(st[1]));

  mc_cu #(.MEM_HS(0), .MEM_LAT(3)) dutC (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(memReady),
    .mem_req(memReq[2]), .iord(iord[2]), .wir(wir[2]), .wpc(wpc[2]), .pcsource(pcsrc[2]),
    .wmem(wmem[2]), .wreg(wreg[2]), .regrt(regrt[2]), .m2reg(m2reg[2]), .jal(jal[2]),
    .shift(shift[2]), .aluimm(aluimm[2]), .sext(sext[2]), .aluc(aluc[2]),
    .illegal(illeg[2]), .state(st[2]));

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Moves to the next stimulus slot: just after the falling edge.
  task automatic applyStimulus;
    @(negedge clock);
    #1;
  endtask

  // One-cycle synchronous reset pulse; returns at the start of the first
  // cycle after release, when every instance is in IF.
  task automatic pulseReset;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 6'b000000; func = 6'b100000; z = 1'b0; memReady = 1'b0;

    // Reset state
    applyStimulus(); applyStimulus(); #1;
    checkOutput("rst_stateA", st[0], 3'd0);
    checkOutput("rst_wirA",   wir[0], 1'b0);
    checkOutput("rst_wpcA",   wpc[0], 1'b0);
    checkOutput("rst_stateC", st[2], 3'd0);

    // add on A (fixed latency 1): IF ID EXE WB; C needs 3 IF cycles
    applyStimulus(); reset = 1'b0; op = 6'b000000; func = 6'b100000; #1;
    checkOutput("add_if_state", st[0], 3'd0);
    checkOutput("add_if_memreq", memReq[0], 1'b1);
    checkOutput("add_if_iord", iord[0], 1'b0);
    checkOutput("add_if_wir", wir[0], 1'b1);
    checkOutput("add_if_wpc", wpc[0], 1'b1);
    checkOutput("add_if_pcsrc", pcsrc[0], 2'b00);
    checkOutput("add_if_wreg", wreg[0], 1'b0);
    checkOutput("lat3_c1_wir", wir[2], 1'b0);
    applyStimulus(); #1;
    checkOutput("add_id_state", st[0], 3'd1);
    checkOutput("add_id_wreg", wreg[0], 1'b0);
    checkOutput("lat3_c2_state", st[2], 3'd0);
    checkOutput("lat3_c2_wir", wir[2], 1'b0);
    applyStimulus(); #1;
    checkOutput("add_exe_state", st[0], 3'd2);
    checkOutput("add_exe_wreg", wreg[0], 1'b0);
    checkOutput("lat3_c3_wir", wir[2], 1'b1);
    applyStimulus(); #1;
    checkOutput("add_wb_state", st[0], 3'd4);
    checkOutput("add_wb_wreg", wreg[0], 1'b1);
    checkOutput("add_wb_aluc", aluc[0], 4'b0000);
    checkOutput("add_wb_regrt", regrt[0], 1'b0);
    checkOutput("lat3_c4_state", st[2], 3'd1);
    applyStimulus(); #1;
    checkOutput("add_done_state", st[0], 3'd0);
    checkOutput("add_done_wreg", wreg[0], 1'b0);

    // lw on B (handshake): MEM held 4 cycles by mem_ready
    pulseReset(); op = 6'b100011; memReady = 1'b1; #1;
    checkOutput("lw_if_state", st[1], 3'd0);
    checkOutput("lw_if_wir", wir[1], 1'b1);
    applyStimulus(); memReady = 1'b0; #1;
    checkOutput("lw_id_state", st[1], 3'd1);
    applyStimulus(); memReady = 1'b1; #1;
    checkOutput("lw_exe_state", st[1], 3'd2);
    checkOutput("lw_exe_memreq", memReq[1], 1'b0);
    applyStimulus(); memReady = 1'b0; #1;
    checkOutput("lw_mem1_state", st[1], 3'd3);
    checkOutput("lw_mem1_memreq", memReq[1], 1'b1);
    checkOutput("lw_mem1_iord", iord[1], 1'b1);
    checkOutput("lw_mem1_wmem", wmem[1], 1'b0);
    applyStimulus(); #1;
    checkOutput("lw_mem2_state", st[1], 3'd3);
    applyStimulus(); #1;
    checkOutput("lw_mem3_state", st[1], 3'd3);
    applyStimulus(); memReady = 1'b1; #1;
    checkOutput("lw_mem4_state", st[1], 3'd3);
    checkOutput("lw_mem4_iord", iord[1], 1'b1);
    applyStimulus(); memReady = 1'b0; #1;
    checkOutput("lw_wb_state", st[1], 3'd4);
    checkOutput("lw_wb_wreg", wreg[1], 1'b1);
    checkOutput("lw_wb_m2reg", m2reg[1], 1'b1);
    checkOutput("lw_wb_regrt", regrt[1], 1'b1);
    checkOutput("lw_wb_sext", sext[1], 1'b1);
    applyStimulus(); #1;
    checkOutput("lw_done_state", st[1], 3'd0);

    // beq on A, taken then not taken
    pulseReset(); op = 6'b000100; z = 1'b1; #1;
    checkOutput("beq1_if_state", st[0], 3'd0);
    applyStimulus(); #1;
    checkOutput("beq1_id_state", st[0], 3'd1);
    applyStimulus(); #1;
    checkOutput("beq1_exe_state", st[0], 3'd2);
    checkOutput("beq1_exe_wpc", wpc[0], 1'b1);
    checkOutput("beq1_exe_pcsrc", pcsrc[0], 2'b01);
    checkOutput("beq1_exe_aluc", aluc[0], 4'b0010);
    applyStimulus(); z = 1'b0; #1;
    checkOutput("beq1_next_state", st[0], 3'd0);
    applyStimulus(); #1;
    checkOutput("beq0_id_state", st[0], 3'd1);
    applyStimulus(); #1;
    checkOutput("beq0_exe_state", st[0], 3'd2);
    checkOutput("beq0_exe_wpc", wpc[0], 1'b0);
    checkOutput("beq0_exe_pcsrc", pcsrc[0], 2'b01);
    applyStimulus(); op = 6'b000011; #1;
    checkOutput("beq0_next_state", st[0], 3'd0);

    // jal on A
    applyStimulus(); #1;
    checkOutput("jal_id_state", st[0], 3'd1);
    checkOutput("jal_id_wpc", wpc[0], 1'b1);
    checkOutput("jal_id_pcsrc", pcsrc[0], 2'b11);
    checkOutput("jal_id_wreg", wreg[0], 1'b1);
    checkOutput("jal_id_jal", jal[0], 1'b1);
    applyStimulus(); op = 6'b000000; func = 6'b001000; #1;
    checkOutput("jal_next_state", st[0], 3'd0);

    // jr on A
    applyStimulus(); #1;
    checkOutput("jr_id_state", st[0], 3'd1);
    checkOutput("jr_id_wpc", wpc[0], 1'b1);
    checkOutput("jr_id_pcsrc", pcsrc[0], 2'b10);
    checkOutput("jr_id_wreg", wreg[0], 1'b0);
    applyStimulus(); op = 6'b111111; #1;
    checkOutput("jr_next_state", st[0], 3'd0);

    // Illegal opcode on A
    applyStimulus(); #1;
    checkOutput("ill_id_state", st[0], 3'd1);
    checkOutput("ill_id_illegal", illeg[0], 1'b1);
    checkOutput("ill_id_wpc", wpc[0], 1'b0);
    checkOutput("ill_id_wreg", wreg[0], 1'b0);
    checkOutput("ill_id_wir", wir[0], 1'b0);
    checkOutput("ill_id_memreq", memReq[0], 1'b0);
    applyStimulus(); op = 6'b101011; #1;
    checkOutput("ill_next_state", st[0], 3'd0);
    checkOutput("ill_next_illegal", illeg[0], 1'b0);

    // sw on A: IF ID EXE MEM then IF
    applyStimulus(); #1;
    checkOutput("swA_id_state", st[0], 3'd1);
    applyStimulus(); #1;
    checkOutput("swA_exe_state", st[0], 3'd2);
    checkOutput("swA_exe_wmem", wmem[0], 1'b0);
    applyStimulus(); #1;
    checkOutput("swA_mem_state", st[0], 3'd3);
    checkOutput("swA_mem_wmem", wmem[0], 1'b1);
    checkOutput("swA_mem_iord", iord[0], 1'b1);
    applyStimulus(); #1;
    checkOutput("swA_next_state", st[0], 3'd0);
    checkOutput("swA_next_wmem", wmem[0], 1'b0);

    // sw on B interrupted by reset while in MEM
    pulseReset(); op = 6'b101011; memReady = 1'b1; #1;
    checkOutput("swB_if_state", st[1], 3'd0);
    applyStimulus(); memReady = 1'b0; #1;
    checkOutput("swB_id_state", st[1], 3'd1);
    applyStimulus(); #1;
    checkOutput("swB_exe_state", st[1], 3'd2);
    applyStimulus(); #1;
    checkOutput("swB_mem_state", st[1], 3'd3);
    checkOutput("swB_mem_wmem", wmem[1], 1'b1);
    reset = 1'b1;
    applyStimulus(); #1;
    checkOutput("swB_rst_state", st[1], 3'd0);
    checkOutput("swB_rst_wmem", wmem[1], 1'b0);
    reset = 1'b0;

    // Datapath selects follow decode regardless of state
    op = 6'b001101; #1;
    checkOutput("ori_aluc", aluc[0], 4'b0101);
    checkOutput("ori_aluimm", aluimm[0], 1'b1);
    checkOutput("ori_sext", sext[0], 1'b0);
    op = 6'b000000; func = 6'b000000; #1;
    checkOutput("sll_aluc", aluc[0], 4'b0011);
    checkOutput("sll_shift", shift[0], 1'b1);
    func = 6'b000011; #1;
    checkOutput("sra_aluc", aluc[0], 4'b1111);
    func = 6'b100010; #1;
    checkOutput("sub_aluc", aluc[0], 4'b0100);
    op = 6'b001111; #1;
    checkOutput("lui_aluc", aluc[0], 4'b0110);
    checkOutput("lui_regrt", regrt[0], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
